// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame running maximum, minimum, first-max index and beat
// count over a valid/ready byte stream. The result is held until it is consumed.
module minmax_tracker #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_max,
  output logic [7:0]       out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The counter tops out here; the max index is bounded by the counter, so it
  // saturates at the same value without extra logic.
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [7:0]       max_q;
  logic [7:0]       min_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] count_q;

  logic [7:0]       max_next;
  logic [7:0]       min_next;
  logic [CNT_W-1:0] idx_next;
  logic [CNT_W-1:0] count_next;

  // Ready whenever a frame can be opened or extended; reset forces it low.
  always_comb begin
    in_ready = (state != HOLD) && !rst;
  end

  // A beat transfers only when both sides agree.
  always_comb begin
    accept = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: open on a first beat, close on the last beat, release on out_ready.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath update: seed on a frame's first beat, strict compare on later beats.
  always_comb begin
    max_next   = max_q;
    min_next   = min_q;
    idx_next   = idx_q;
    count_next = count_q;
    if (accept) begin
      if (state == IDLE) begin
        max_next   = in_data;
        min_next   = in_data;
        idx_next   = '0;
        count_next = CNT_ONE;
      end else if (state == ACCUM) begin
        if (in_data > max_q) begin
          max_next = in_data;
          idx_next = count_q;
        end
        if (in_data < min_q) begin
          min_next = in_data;
        end
        if (count_q != CNT_SAT) begin
          count_next = count_q + CNT_ONE;
        end
      end
    end
  end

  // Result registers; they only move on accepted beats, so they stay frozen in HOLD and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      max_q   <= max_next;
      min_q   <= min_next;
      idx_q   <= idx_next;
      count_q <= count_next;
    end
  end

  // The result is presented exactly while the frame is parked in HOLD.
  always_comb begin
    out_valid   = (state == HOLD);
    out_max     = max_q;
    out_min     = min_q;
    out_max_idx = idx_q;
    out_count   = count_q;
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: randomized and directed frames; a queue-based scoreboard
// checks every presented result against a reference computed from whole frames.
module tb_minmax_tracker;

  localparam int CNT_W = 9;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_max;
  logic [7:0]       out_min;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    int mx;
    int mn;
    int idx;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   frame_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;

  minmax_tracker #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_max_idx(out_max_idx),
    .out_count  (out_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference result of the whole frame held in frame_q.
  function automatic exp_t model();
    exp_t e;
    int   mq[$];
    int   nq[$];
    int   iq[$];
    mq = frame_q.max();
    nq = frame_q.min();
    e.mx = mq[0];
    e.mn = nq[0];
    iq = frame_q.find_first_index(x) with (x == e.mx);
    e.idx = (iq[0] > SAT) ? SAT : iq[0];
    e.cnt = (frame_q.size() > SAT) ? SAT : frame_q.size();
    return e;
  endfunction

  // Consumer side: forced low, forced high, or random back-pressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = (($urandom % 3) != 0);
      endcase
    end
  end

  // Monitor: every presented result must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(out_valid), 0);
        end else begin
          check("out_max", int'(out_max), exp_q[0].mx);
          check("out_min", int'(out_min), exp_q[0].mn);
          check("out_max_idx", int'(out_max_idx), exp_q[0].idx);
          check("out_count", int'(out_count), exp_q[0].cnt);
          check("in_ready_in_hold", int'(in_ready), 0);
          if (out_ready) begin
            exp_q.delete(0);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finish_tb();
  end

  task automatic apply_stimulus(input int data, input bit last, input int gap);
    int  waited;
    bit  done;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = 8'(data);
    in_last  = last;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          check("in_ready_timeout", int'(in_ready), 1);
          finish_tb();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sends frame_q from beat 'first' on, then queues the expected result.
  task automatic send_frame(input int gap_max, input bit drop, input int first);
    for (int i = first; i < frame_q.size(); i++) begin
      apply_stimulus(frame_q[i], (i == frame_q.size() - 1),
                     (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    end
    exp_q.push_back(model());
    check("latency_out_valid", int'(out_valid), 1);
    if (drop) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int v, input int mx, input int mn,
                              input int idx, input int cnt);
    check({tag, "_valid"}, int'(out_valid), v);
    check({tag, "_max"}, int'(out_max), mx);
    check({tag, "_min"}, int'(out_min), mn);
    check({tag, "_idx"}, int'(out_max_idx), idx);
    check({tag, "_count"}, int'(out_count), cnt);
  endtask

  // Main sequence: reset, directed frames, reset mid-frame, back-to-back, random.
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset", 0, 0, 0, 0, 0);
    check("reset_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ready_mode = 2;
    frame_q = '{5, 200, 17, 200, 3};
    send_frame(0, 1, 0);
    frame_q = '{255, 0, 255, 0};
    send_frame(0, 1, 0);
    wait_drain();

    ready_mode = 1;
    frame_q = '{128};
    send_frame(0, 1, 0);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
    end
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("after_hold_valid", int'(out_valid), 0);
    check("after_hold_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    ready_mode = 0;
    frame_q.delete();
    for (int i = 0; i < 515; i++) frame_q.push_back(8'h11);
    send_frame(0, 1, 0);
    frame_q.delete();
    for (int i = 0; i < 520; i++) frame_q.push_back((i == 515) ? 8'h20 : 8'h10);
    send_frame(0, 1, 0);
    frame_q.delete();
    for (int i = 0; i < 400; i++) frame_q.push_back((i == 300) ? 250 : $urandom_range(0, 100));
    send_frame(1, 1, 0);
    wait_drain();

    apply_stimulus(50, 1'b0, 0);
    apply_stimulus(60, 1'b0, 0);
    apply_stimulus(70, 1'b0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("midrst", 0, 0, 0, 0, 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b0;
    @(negedge clk);
    check("first_edge_in_ready", int'(in_ready), 1);
    check_output("postrst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    frame_q = '{9, 4};
    send_frame(0, 1, 1);
    wait_drain();

    ready_mode = 2;
    frame_q = '{30, 90, 90, 10};
    send_frame(0, 0, 0);
    frame_q = '{7, 8, 6};
    send_frame(0, 1, 0);
    wait_drain();

    ready_mode = 0;
    for (int f = 0; f < 30; f++) begin
      int len;
      bit narrow;
      len    = $urandom_range(1, 24);
      narrow = $urandom_range(0, 1);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        frame_q.push_back(narrow ? $urandom_range(0, 7) : $urandom_range(0, 255));
      end
      send_frame(2, $urandom_range(0, 1), 0);
    end
    in_valid = 1'b0;
    wait_drain();
    finish_tb();
  end

endmodule

// File: doc/minmax_tracker.md
MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 Parameter: CNT_W, default 9, width of the sample counter and of the max-index output.
REQ-002 Port: clk  input  1  single clock; all state on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  input beat valid.
REQ-005 Port: in_data  input  8  unsigned sample.
REQ-006 Port: in_last  input  1  marks final beat of a frame; qualified by in_valid.
REQ-007 Port: in_ready  output  1  block can accept a beat.
REQ-008 Port: out_valid  output  1  frame result valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out_max  output  8  largest sample of the frame.
REQ-011 Port: out_min  output  8  smallest sample of the frame.
REQ-012 Port: out_max_idx  output  CNT_W  zero-based index of the first occurrence of out_max.
REQ-013 Port: out_count  output  CNT_W  number of beats in the frame, saturating.

Function
REQ-014 An input beat SHALL be accepted only on a clock edge where in_valid=1 and in_ready=1.
REQ-015 The FSM SHALL have exactly three states: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD, and 0 while rst is high.
REQ-017 IDLE, accepted beat: max=min=in_data, max_idx=0, count=1; next state is HOLD if in_last=1, otherwise ACCUM.
REQ-018 ACCUM, accepted beat: max is replaced only if in_data > max (unsigned); min is replaced only if in_data < min; count increments.
REQ-019 ACCUM, accepted beat: max_idx takes the pre-increment count value only when max is replaced; ties SHALL NOT update max_idx.
REQ-020 ACCUM, accepted beat with in_last=1: the beat is included in the result and the next state is HOLD.
REQ-021 Beat-tracking count SHALL saturate at 2^CNT_W-1; further beats still update max/min.
REQ-022 When the max replacement index is at or above 2^CNT_W-1, max_idx SHALL hold the saturated value 2^CNT_W-1.
REQ-023 ACCUM with no accepted beat: all registers hold, with no timeout.
REQ-024 out_valid SHALL be 1 exactly while in HOLD; it rises on the cycle after the in_last beat is accepted (1-cycle latency).
REQ-025 out_max, out_min, out_max_idx and out_count SHALL be registered and stable throughout HOLD.
REQ-026 HOLD with out_ready=1 SHALL transition to IDLE on that edge; HOLD with out_ready=0 SHALL stay in HOLD indefinitely.
REQ-027 out_ready SHALL be ignored outside HOLD.
REQ-028 Result outputs SHALL keep their last values in IDLE until the next first beat of a frame is accepted.
REQ-029 A single-beat frame (in_last on the first beat) SHALL yield max=min=that sample, max_idx=0, count=1.
REQ-030 Back-to-back frames: a beat presented in the cycle HOLD exits SHALL NOT be accepted; acceptance resumes in the next cycle, in IDLE.

Reset
REQ-031 While rst=1, regardless of clk: state=IDLE, out_valid=0, out_max=0, out_min=0, out_max_idx=0, out_count=0.
REQ-032 Assertion of rst mid-frame or during HOLD SHALL discard the partial or pending result with no output pulse.
REQ-033 The first edge after rst deasserts SHALL be able to accept a beat.

Verification
REQ-034 Frame 5,200,17,200,3 (last on 3), out_ready=1 -> one cycle later out_valid=1, max=200, min=3, max_idx=1, count=5.
REQ-035 Single beat 0x80 with in_last, out_ready=0 for 10 cycles -> out_valid stays 1, in_ready=0, outputs 0x80/0x80/0/1 stable; out_ready=1 -> IDLE the next cycle.
REQ-036 Frame 0xFF,0x00,0xFF,0x00 -> max=0xFF, min=0x00, max_idx=0, count=4.
REQ-037 Frame of 515 beats of 0x11 with CNT_W=9 -> count=511, max=min=0x11, max_idx=0.
REQ-038 rst pulsed after 3 beats of a frame -> out_valid never asserts; all outputs read 0; the next frame 9,4 (last) -> max=9, min=4, max_idx=0, count=2.
REQ-039 in_valid held high with gaps removed, two frames back-to-back -> the beat in the HOLD-exit cycle is not accepted; both results match golden values.
